iter_counter: RTL

Parametrised iteration counter for the shift-add multiplier controllers. It counts `step` strobes from a start value up to a runtime-loadable terminal count and reports completion as a level (`done`) and as a one-cycle pulse (`done_pulse`). It also supports a wrap (auto-reload) mode for back-to-back operations, a `remaining` count, and sticky error flags. It replaces fixed-length iteration counters in the control path. With default parameters and no `load_tc`, it reaches `done` after 15 steps from reset, matching the 16-cycle multiply sequence.

---
 rtl/iter_counter.sv | 102 ++++++++++
 1 files changed

// File: rtl/iter_counter.sv
// Iteration counter for the shift-add multiplier controllers: counts step strobes
// from START_VAL up to a loadable terminal count, with saturate or auto-reload behaviour.
module iter_counter #(
    parameter int CNT_W      = 5,
    parameter int START_VAL  = 1,
    parameter int DEFAULT_TC = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             load_tc,
    input  logic [CNT_W-1:0] tc_in,
    input  logic             step,
    input  logic             mode,
    output logic [CNT_W-1:0] count,
    output logic [CNT_W-1:0] remaining,
    output logic             done,
    output logic             done_pulse,
    output logic             wrap_pulse,
    output logic             ovf_err,
    output logic             cfg_err
);

    localparam logic [CNT_W-1:0] START_V = CNT_W'(START_VAL);
    localparam logic [CNT_W-1:0] DEF_TC  = CNT_W'(DEFAULT_TC);

    logic [CNT_W-1:0] count_reg, count_next;
    logic [CNT_W-1:0] tc_reg, tc_next;
    logic             done_pulse_reg, done_pulse_next;
    logic             wrap_pulse_reg, wrap_pulse_next;
    logic             ovf_err_reg, ovf_err_next;
    logic             cfg_err_reg, cfg_err_next;

    logic             at_tc;
    logic [CNT_W-1:0] count_inc;

    // count is never allowed past tc, so equality alone identifies terminal count
    assign at_tc     = (count_reg == tc_reg);
    assign count_inc = count_reg + CNT_W'(1);

    always_comb begin
        count_next      = count_reg;
        tc_next         = tc_reg;
        done_pulse_next = 1'b0;
        wrap_pulse_next = 1'b0;
        ovf_err_next    = ovf_err_reg;
        cfg_err_next    = cfg_err_reg;

        if (clear) begin
            count_next   = START_V;
            ovf_err_next = 1'b0;
            cfg_err_next = 1'b0;
        end else if (load_tc) begin
            // A terminal count at or below the start value would never be reached by counting up
            if (tc_in > START_V) begin
                tc_next      = tc_in;
                count_next   = START_V;
                ovf_err_next = 1'b0;
                cfg_err_next = 1'b0;
            end else begin
                cfg_err_next = 1'b1;
            end
        end else if (step) begin
            if (!at_tc) begin
                count_next      = count_inc;
                done_pulse_next = (count_inc == tc_reg);
            end else if (mode) begin
                count_next      = START_V;
                wrap_pulse_next = 1'b1;
            end else begin
                ovf_err_next = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg      <= START_V;
            tc_reg         <= DEF_TC;
            done_pulse_reg <= 1'b0;
            wrap_pulse_reg <= 1'b0;
            ovf_err_reg    <= 1'b0;
            cfg_err_reg    <= 1'b0;
        end else begin
            count_reg      <= count_next;
            tc_reg         <= tc_next;
            done_pulse_reg <= done_pulse_next;
            wrap_pulse_reg <= wrap_pulse_next;
            ovf_err_reg    <= ovf_err_next;
            cfg_err_reg    <= cfg_err_next;
        end
    end

    assign count      = count_reg;
    assign remaining  = tc_reg - count_reg;
    assign done       = at_tc;
    assign done_pulse = done_pulse_reg;
    assign wrap_pulse = wrap_pulse_reg;
    assign ovf_err    = ovf_err_reg;
    assign cfg_err    = cfg_err_reg;

endmodule
